// File: rtl/router_input_rx.sv
// ============================================================================
// router_input_rx : link receiver with per-VC show-ahead FIFOs, on/off flow
//                   control with hysteresis and per-VC packet allocation FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

package noc_params;
    localparam int VC_NUM    = 4;
    localparam int VC_ID_W   = 3;
    localparam int PAYLOAD_W = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t                flit_label;
        logic [VC_ID_W-1:0]         vc_id;
        logic [PAYLOAD_W-1:0]       payload;
    } flit_t;
endpackage

module router_input_rx
    import noc_params::*;
#(
    parameter int VC_NUM      = noc_params::VC_NUM,
    parameter int BUFFER_SIZE = 8,
    parameter int OFF_MARGIN  = 2,
    parameter int ON_LEVEL    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  flit_t                   data_i,
    input  logic                    is_valid_i,
    output logic [VC_NUM-1:0]       is_on_off_o,
    output logic [VC_NUM-1:0]       is_allocatable_o,
    output flit_t [VC_NUM-1:0]      flit_o,
    output logic [VC_NUM-1:0]       flit_valid_o,
    input  logic [VC_NUM-1:0]       read_i,
    output logic [VC_NUM-1:0]       overflow_o,
    output logic [VC_NUM-1:0]       protocol_err_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        localparam logic [VC_ID_W-1:0] VC_ID = VC_ID_W'(v);

        logic [PTR_W-1:0] wr_ptr, rd_ptr;
        logic [CNT_W-1:0] count, count_next;
        logic [1:0]       state, state_next;
        logic             hit, push, pop, err_set;
        logic             on_off, overflow, perr, allocatable;
        flit_t            mem [BUFFER_SIZE];

        assign hit  = is_valid_i && (data_i.vc_id == VC_ID);
        assign pop  = read_i[v] && (count != '0);
        // A full FIFO still accepts when the same edge frees a slot.
        assign push = hit && ((count != CNT_W'(BUFFER_SIZE)) || pop);

        always_comb begin
            count_next = count;
            if (push && !pop)
                count_next = count + CNT_W'(1);
            else if (pop && !push)
                count_next = count - CNT_W'(1);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                on_off   <= 1'b1;
                overflow <= 1'b0;
                perr     <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count_next;
                if (count_next >= CNT_W'(BUFFER_SIZE - OFF_MARGIN))
                    on_off <= 1'b0;
                else if (count_next <= CNT_W'(ON_LEVEL))
                    on_off <= 1'b1;
                if (hit && !push)
                    overflow <= 1'b1;
                if (err_set)
                    perr <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (push)
                mem[wr_ptr] <= data_i;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                state <= IDLE;
            else
                state <= state_next;
        end

        always_comb begin
            state_next = state;
            err_set    = 1'b0;
            case (state)
                IDLE: begin
                    if (push) begin
                        case (data_i.flit_label)
                            HEAD:     state_next = BUSY;
                            HEADTAIL: state_next = DRAIN;
                            default:  err_set    = 1'b1;
                        endcase
                    end
                end
                BUSY: begin
                    if (push) begin
                        case (data_i.flit_label)
                            TAIL:     state_next = DRAIN;
                            BODY:     state_next = BUSY;
                            default:  err_set    = 1'b1;
                        endcase
                    end
                end
                DRAIN: begin
                    // The packet is closed; nothing may arrive until it drains.
                    if (push)
                        err_set = 1'b1;
                    else if (count_next == '0)
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end

        always_comb begin
            allocatable = (state == IDLE);
        end

        assign flit_o[v]           = mem[rd_ptr];
        assign flit_valid_o[v]     = (count != '0);
        assign is_on_off_o[v]      = on_off;
        assign is_allocatable_o[v] = allocatable;
        assign overflow_o[v]       = overflow;
        assign protocol_err_o[v]   = perr;
    end

endmodule

`default_nettype wire
